latch_bank_arbiter: RTL and testbench
=====================================

LATCH_BANK_ARBITER -- requirements
Module: latch_bank_arbiter

Interface
REQ-001 Parameter N, 4, number of requesters (2..8).
REQ-002 Parameter DW, 8, data width of the latch bank.
REQ-003 Parameter ENTRIES, 4, number of D latches in the bank, each with its own enable.
REQ-004 Parameter AW, 2, address width: ceil(log2(ENTRIES)), minimum 1.
REQ-005 Parameter OPEN_CYC, 1, cycles a latch enable stays high (1..15).
REQ-006 Port clk  input  1  rising-edge clock.
REQ-007 Port reset  input  1  reset, synchronous, active-high.
REQ-008 Port req  input  N  per-requester write request; held high until ack.
REQ-009 Port wr_addr  input  N*AW  flat packed target entry per requester; requester i occupies bits [i*AW +: AW].
REQ-010 Port wr_data  input  N*DW  flat packed write data per requester; requester i occupies bits [i*DW +: DW].
REQ-011 Port ack  output  N  one-hot, one-cycle completion pulse.
REQ-012 Port latch_en  output  ENTRIES  one-hot enables to the latch bank.
REQ-013 Port latch_d  output  DW  shared data bus to all latch D inputs.
REQ-014 Port busy  output  1  high in every state except IDLE.
REQ-015 Port err  output  1  one-cycle pulse, coincident with ack, when the granted address is >= ENTRIES.

Function
REQ-016 The FSM SHALL have the states IDLE, SETUP, OPEN and HOLD.
REQ-017 IDLE with any req high: pick a winner, capture its addr and data into internal registers, then go to SETUP at the next edge.
REQ-018 SETUP: drive latch_d with the captured data; all latch_en low; lasts exactly 1 cycle.
REQ-019 OPEN: latch_en[addr]=1 for exactly OPEN_CYC cycles; latch_d stable; then go to HOLD.
REQ-020 HOLD: all latch_en low; latch_d still held; ack[winner]=1 for 1 cycle; then go to IDLE.
REQ-021 Latency: ack SHALL be high in cycle OPEN_CYC+2 after the IDLE capture edge; back-to-back transactions SHALL repeat every OPEN_CYC+3 cycles.
REQ-022 Arbitration: round-robin starting from pointer ptr; after each ack, ptr becomes winner+1 mod N.
REQ-023 latch_d SHALL change only on entry to SETUP; it SHALL never change while any latch_en is high.
REQ-024 At most one latch_en bit SHALL be high in any cycle.
REQ-025 Address >= ENTRIES: no latch_en asserted during OPEN; the FSM still walks all states; ack and err are pulsed.
REQ-026 A req dropped after capture SHALL NOT abort the transaction; ack is still pulsed.
REQ-027 A req rising outside IDLE SHALL wait; it is not lost while held.
REQ-028 Requests SHALL only be sampled in IDLE; a requester that drops req on the edge where ack is seen SHALL NOT be re-granted.
REQ-029 All outputs SHALL be registered or decoded from the state register only; no combinational path from req to any output.

Reset
REQ-030 On reset: state=IDLE, ptr=0, latch_en=0, latch_d=0, ack=0, err=0, busy=0, all effective at the first edge with reset high.
REQ-031 Reset mid-transaction (any state): latch_en low at the next edge, no ack is issued, and the transaction is discarded.

Configuration
REQ-032 Macro LATCH_ARB_FIXED_PRIO_EN defined: fixed priority, lowest index wins, and ptr is unused (may be optimised away).
REQ-033 Macro LATCH_ARB_FIXED_PRIO_EN undefined: round-robin per REQ-022.

Verification (N=4, DW=8, ENTRIES=4, OPEN_CYC=1)
REQ-034 Reset, then req=0001, addr0=2, data0=8'hA5: SETUP latch_d=A5; next cycle latch_en=0100; next cycle ack=0001, err=0; latch_en never overlaps a latch_d change.
REQ-035 req=1111 held, each requester dropping req on its ack: acks in order 0001, 0010, 0100, 1000, spaced 4 cycles apart; with LATCH_ARB_FIXED_PRIO_EN defined, the same sequence.
REQ-036 req=0110 held continuously, requester 1 re-requesting after each ack: grants alternate between requesters 1 and 2; neither is starved.
REQ-037 Parameters ENTRIES=3, AW=2, requester 0 addr=3, data=8'h3C: latch_en stays 000 throughout; ack=0001 and err=1 in the same cycle.
REQ-038 reset asserted during OPEN: latch_en=0 at the next edge; no ack; busy=0; the next request is granted starting from ptr=0.
REQ-039 OPEN_CYC=3: latch_en[addr] high for exactly 3 consecutive cycles; ack 5 cycles after the capture edge.

Source files
------------

// File: rtl/latch_bank_arbiter.sv
// latch_bank_arbiter: N requesters compete for writes into a bank of ENTRIES
// D latches. Each write walks SETUP (data settles on latch_d), OPEN (one latch
// enable high for OPEN_CYC cycles) and HOLD (data still held, ack pulsed), so
// the latch data never moves while an enable is open.
// Optional build macro: LATCH_ARB_FIXED_PRIO_EN selects fixed priority (lowest
// index wins) instead of the default round-robin arbitration.
module latch_bank_arbiter #(
    parameter int N        = 4,
    parameter int DW       = 8,
    parameter int ENTRIES  = 4,
    parameter int AW       = 2,
    parameter int OPEN_CYC = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N-1:0]         req,
    input  logic [N*AW-1:0]      wr_addr,
    input  logic [N*DW-1:0]      wr_data,
    output logic [N-1:0]         ack,
    output logic [ENTRIES-1:0]   latch_en,
    output logic [DW-1:0]        latch_d,
    output logic                 busy,
    output logic                 err
);

    localparam int              WW       = (N > 1) ? $clog2(N) : 1;
    localparam logic [AW:0]     ENT_W    = (AW+1)'(ENTRIES);
    localparam logic [3:0]      CNT_LAST = 4'(OPEN_CYC - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        OPEN  = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [WW-1:0]        win_q, win_d;
    logic [AW-1:0]        addr_q, addr_d;
    logic [3:0]           cnt_q, cnt_d;
    logic [DW-1:0]        latch_d_q, latch_d_d;
    logic [ENTRIES-1:0]   latch_en_q, latch_en_d;
    logic [N-1:0]         ack_q, ack_d;
    logic                 err_q, err_d;

    logic                 pick_valid_s;
    logic [WW-1:0]        pick_idx_s;
    logic [AW-1:0]        pick_addr_s;
    logic [DW-1:0]        pick_data_s;
    logic                 addr_bad_s;

    // One-hot latch enable for an address; out-of-range addresses decode to zero.
    function automatic logic [ENTRIES-1:0] entry_decode(input logic [AW-1:0] a);
        logic [ENTRIES-1:0] dec;
        dec = '0;
        for (int e = 0; e < ENTRIES; e++) begin
            dec[e] = (a == AW'(e));
        end
        return dec;
    endfunction

`ifndef LATCH_ARB_FIXED_PRIO_EN
    logic [WW-1:0] ptr_q, ptr_d;

    // Round-robin pointer advances past the winner once its ack goes out.
    always_comb begin
        ptr_d = ptr_q;
        if (state_q == HOLD) begin
            if (win_q == WW'(N - 1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = win_q + WW'(1);
            end
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Round-robin pointer register.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`endif

    // Winner selection: first active request scanning from the priority start.
    always_comb begin
        int idx;
        pick_valid_s = 1'b0;
        pick_idx_s   = '0;
        pick_addr_s  = '0;
        pick_data_s  = '0;
        idx          = 0;
        for (int k = 0; k < N; k++) begin
`ifdef LATCH_ARB_FIXED_PRIO_EN
            idx = k;
`else
            idx = (int'(ptr_q) + k) % N;
`endif
            if (!pick_valid_s && req[idx]) begin
                pick_valid_s = 1'b1;
                pick_idx_s   = WW'(idx);
                pick_addr_s  = wr_addr[idx*AW +: AW];
                pick_data_s  = wr_data[idx*DW +: DW];
            end else begin
                pick_valid_s = pick_valid_s;
            end
        end
    end

    assign addr_bad_s = ({1'b0, addr_q} >= ENT_W);

    // Next state and next registered outputs; outputs default to idle values.
    always_comb begin
        state_d    = state_q;
        win_d      = win_q;
        addr_d     = addr_q;
        cnt_d      = cnt_q;
        latch_d_d  = latch_d_q;
        latch_en_d = '0;
        ack_d      = '0;
        err_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_valid_s) begin
                    win_d     = pick_idx_s;
                    addr_d    = pick_addr_s;
                    latch_d_d = pick_data_s;
                    state_d   = SETUP;
                end else begin
                    state_d   = IDLE;
                end
            end
            SETUP: begin
                cnt_d      = 4'd0;
                latch_en_d = entry_decode(addr_q);
                state_d    = OPEN;
            end
            OPEN: begin
                if (cnt_q == CNT_LAST) begin
                    ack_d   = {{(N-1){1'b0}}, 1'b1} << win_q;
                    err_d   = addr_bad_s;
                    state_d = HOLD;
                end else begin
                    cnt_d      = cnt_q + 4'd1;
                    latch_en_d = entry_decode(addr_q);
                    state_d    = OPEN;
                end
            end
            HOLD: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, captured transaction and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            win_q      <= '0;
            addr_q     <= '0;
            cnt_q      <= 4'd0;
            latch_d_q  <= '0;
            latch_en_q <= '0;
            ack_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            win_q      <= win_d;
            addr_q     <= addr_d;
            cnt_q      <= cnt_d;
            latch_d_q  <= latch_d_d;
            latch_en_q <= latch_en_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
        end
    end

    assign latch_en = latch_en_q;
    assign latch_d  = latch_d_q;
    assign ack      = ack_q;
    assign err      = err_q;
    assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_latch_bank_arbiter.sv
// Bench for latch_bank_arbiter: two configurations (ENTRIES=4/OPEN_CYC=1 and
// ENTRIES=3/OPEN_CYC=3) each run directed scenarios and random traffic against
// a transaction-level model tracking the cycle count since capture.
module tb_latch_bank_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int AW = 2;

    logic clk;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   done_cnt = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input int cfg, input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL cfg%0d %s: got 0x%0h expected 0x%0h", cfg, nm, act, exp);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : cfg
        localparam int ENT = (g == 0) ? 4 : 3;
        localparam int OC  = (g == 0) ? 1 : 3;

        logic              rst;
        logic [N-1:0]      req;
        logic [N*AW-1:0]   wa;
        logic [N*DW-1:0]   wd;
        logic [N-1:0]      ack;
        logic [ENT-1:0]    en;
        logic [DW-1:0]     ld;
        logic              busy, err;
        logic [AW-1:0]     a_arr [N];
        logic [DW-1:0]     d_arr [N];

        for (genvar i = 0; i < N; i++) begin : pk
            assign wa[i*AW +: AW] = a_arr[i];
            assign wd[i*DW +: DW] = d_arr[i];
        end

        latch_bank_arbiter #(.N(N), .DW(DW), .ENTRIES(ENT), .AW(AW), .OPEN_CYC(OC)) dut (
            .clk(clk), .reset(rst), .req(req), .wr_addr(wa), .wr_data(wd),
            .ack(ack), .latch_en(en), .latch_d(ld), .busy(busy), .err(err)
        );

        // Model: m_t counts cycles since the capture edge (1 = SETUP cycle).
        bit            m_act = 1'b0;
        int            m_t = 0, m_win = 0, m_addr = 0, m_ptr = 0;
        logic [DW-1:0] m_ld = '0;
        int            e_ack = 0, e_en = 0;
        bit            e_err = 1'b0;

        task automatic tick();
            if (rst) begin
                m_act = 1'b0; m_ptr = 0; m_ld = '0;
            end else if (!m_act) begin
                if (|req) begin
                    int w;
                    w = -1;
                    for (int k = 0; k < N; k++) begin
                        int i;
`ifdef LATCH_ARB_FIXED_PRIO_EN
                        i = k;
`else
                        i = (m_ptr + k) % N;
`endif
                        if (w < 0 && req[i]) w = i;
                    end
                    m_act = 1'b1; m_t = 1; m_win = w;
                    m_addr = int'(a_arr[w]); m_ld = d_arr[w];
                end
            end else if (m_t == OC + 2) begin
                m_act = 1'b0; m_ptr = (m_win + 1) % N;
            end else begin
                m_t++;
            end
            @(posedge clk);
            @(negedge clk);
            e_en  = (m_act && m_t >= 2 && m_t <= OC + 1 && m_addr < ENT) ? (1 << m_addr) : 0;
            e_ack = (m_act && m_t == OC + 2) ? (1 << m_win) : 0;
            e_err = m_act && (m_t == OC + 2) && (m_addr >= ENT);
            check(g, "latch_en", 32'(en),   32'(e_en));
            check(g, "ack",      32'(ack),  32'(e_ack));
            check(g, "err",      32'(err),  32'(e_err));
            check(g, "busy",     32'(busy), 32'(m_act));
            check(g, "latch_d",  32'(ld),   32'(m_ld));
        endtask

        task automatic rand_phase(input int cycles);
            bit outst [N];
            bit drop  [N];
            for (int i = 0; i < N; i++) begin outst[i] = 1'b0; drop[i] = 1'b0; end
            for (int c = 0; c < cycles; c++) begin
                rst = 1'b0;
                for (int i = 0; i < N; i++) begin
                    if (e_ack[i]) begin outst[i] = 1'b0; drop[i] = 1'b0; end
                    if (!outst[i] && $urandom_range(0, 3) == 0) begin
                        outst[i] = 1'b1;
                        a_arr[i] = AW'($urandom_range(0, 3));
                        d_arr[i] = DW'($urandom);
                    end
                    if (outst[i] && m_act && m_win == i && $urandom_range(0, 5) == 0) drop[i] = 1'b1;
                end
                if ($urandom_range(0, 149) == 0) begin
                    rst = 1'b1;
                    for (int i = 0; i < N; i++) begin outst[i] = 1'b0; drop[i] = 1'b0; end
                end
                for (int i = 0; i < N; i++) req[i] = outst[i] && !drop[i];
                tick();
            end
            rst = 1'b0;
            req = '0;
            tick();
        endtask

        if (g == 0) begin : d0
            initial begin
                int k, last;
                rst = 1'b1; req = '0;
                for (int i = 0; i < N; i++) begin a_arr[i] = '0; d_arr[i] = '0; end
                @(negedge clk);
                tick();
                check(g, "rst_busy", 32'(busy), 32'h0);
                check(g, "rst_latch_d", 32'(ld), 32'h0);
                check(g, "rst_en", 32'(en), 32'h0);
                rst = 1'b0;
                // single write, addr 2, data A5
                a_arr[0] = 2'd2; d_arr[0] = 8'hA5; req = 4'b0001;
                tick();
                check(g, "setup_latch_d", 32'(ld), 32'hA5);
                check(g, "setup_en", 32'(en), 32'h0);
                tick();
                check(g, "open_en", 32'(en), 32'h4);
                tick();
                check(g, "hold_ack", 32'(ack), 32'h1);
                check(g, "hold_err", 32'(err), 32'h0);
                req = '0;
                tick();
                check(g, "idle_busy", 32'(busy), 32'h0);
                // all four requesting, each drops on its ack
                rst = 1'b1; tick(); rst = 1'b0;
                for (int i = 0; i < N; i++) begin a_arr[i] = AW'(i); d_arr[i] = DW'(8'h10 + i); end
                req = 4'b1111; k = 0; last = 0;
                for (int c = 1; c <= 24 && k < 4; c++) begin
                    tick();
                    if (ack != '0) begin
                        check(g, "order_ack", 32'(ack), 32'(1 << k));
                        if (k > 0) check(g, "ack_spacing", 32'(c - last), 32'd4);
                        last = c; req = req & ~ack; k++;
                    end
                end
                check(g, "ack_count", 32'(k), 32'd4);
                // move ptr to 2, then reset during OPEN of requester 3
                tick();
                req = 4'b0010; tick(); tick(); tick();
                check(g, "ptr_prep_ack", 32'(ack), 32'h2);
                req = '0; tick();
                req = 4'b1000; tick(); tick();
                check(g, "open3_en", 32'(en), 32'h8);
                rst = 1'b1; tick();
                check(g, "rst_open_en", 32'(en), 32'h0);
                check(g, "rst_open_busy", 32'(busy), 32'h0);
                check(g, "rst_open_ack", 32'(ack), 32'h0);
                rst = 1'b0; req = 4'b1001; tick(); tick(); tick();
                check(g, "post_rst_ptr0", 32'(ack), 32'h1);
                req = 4'b1000; tick(); tick(); tick(); tick();
                check(g, "held_req_served", 32'(ack), 32'h8);
                req = '0;
                // requesters 1 and 2 re-requesting after every ack
                rst = 1'b1; tick(); rst = 1'b0;
                req = 4'b0110; k = 0;
                for (int c = 0; c < 40 && k < 4; c++) begin
                    tick();
                    if (ack != '0) begin
`ifdef LATCH_ARB_FIXED_PRIO_EN
                        check(g, "fixed_prio_ack", 32'(ack), 32'h2);
`else
                        check(g, "rr_alternate", 32'(ack), (k % 2 == 0) ? 32'h2 : 32'h4);
`endif
                        req = 4'b0110 & ~ack; k++;
                    end else begin
                        req = 4'b0110;
                    end
                end
                check(g, "rr_count", 32'(k), 32'd4);
                req = '0; tick();
                rand_phase(2000);
                done_cnt++;
            end
        end else begin : d1
            initial begin
                int en_cnt, first, ackc;
                rst = 1'b1; req = '0;
                for (int i = 0; i < N; i++) begin a_arr[i] = '0; d_arr[i] = '0; end
                @(negedge clk);
                tick();
                check(g, "rst_busy", 32'(busy), 32'h0);
                rst = 1'b0;
                // out-of-range address 3 with ENTRIES=3
                a_arr[0] = 2'd3; d_arr[0] = 8'h3C; req = 4'b0001;
                for (int c = 1; c <= 5; c++) begin
                    tick();
                    check(g, "bad_addr_en", 32'(en), 32'h0);
                end
                check(g, "bad_addr_ack", 32'(ack), 32'h1);
                check(g, "bad_addr_err", 32'(err), 32'h1);
                req = '0; tick();
                // OPEN_CYC=3 enable width and ack latency
                a_arr[0] = 2'd1; d_arr[0] = 8'h5A; req = 4'b0001;
                en_cnt = 0; first = -1; ackc = -1;
                for (int c = 1; c <= 6; c++) begin
                    tick();
                    if (en == 3'b010) begin en_cnt++; if (first < 0) first = c; end
                    if (ack == 4'b0001 && ackc < 0) ackc = c;
                    if (ack != '0) req = '0;
                end
                check(g, "open_cycles", 32'(en_cnt), 32'd3);
                check(g, "open_first", 32'(first), 32'd2);
                check(g, "ack_latency", 32'(ackc), 32'd5);
                rand_phase(2000);
                done_cnt++;
            end
        end
    end

    initial begin
        for (int i = 0; i < 20000 && done_cnt < 2; i++) @(posedge clk);
        if (done_cnt < 2) begin
            n_checks++;
            n_fail++;
            $display("FAIL timeout: finished configs %0d expected 2", done_cnt);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
